// File: rtl/data_sram_responder.sv
// data_sram_responder: data SRAM responder with byte-writable RAM and an MMIO register window
//   clk, resetn          clock and asynchronous active-low reset
//   data_sram_en/wen     request strobe and byte write enables (wen==0 is a read)
//   data_sram_addr/wdata byte address and lane-aligned store data
//   data_sram_rdata      registered read data, one cycle after the request
//   switch / led         board switches in, LED register out
//   timer_irq            timer match flag (STATUS bit 0)
module data_sram_responder #(
  parameter int          RAM_AW    = 12,
  parameter logic [31:0] MMIO_BASE = 32'hbfaf_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic        timer_irq
);
  logic [31:0] r_ram [2**RAM_AW];
  logic [31:0] r_rdata, r_timer, r_compare;
  logic [15:0] r_led;
  logic [7:0]  r_sw_meta, r_sw_sync;
  logic        r_status;
  logic [RAM_AW-1:0] w_idx;
  logic [13:0] w_off;
  logic [31:0] w_mask, w_mmio_rd;
  logic        w_mmio, w_wr, w_led_we, w_tmr_we, w_cmp_we, w_st_clr, w_unused;
  assign w_idx    = data_sram_addr[RAM_AW+1:2];
  assign w_off    = data_sram_addr[15:2];
  assign w_mmio   = data_sram_addr[31:16] == MMIO_BASE[31:16];
  assign w_unused = ^data_sram_addr[1:0];
  assign w_mask   = {{8{data_sram_wen[3]}}, {8{data_sram_wen[2]}}, {8{data_sram_wen[1]}}, {8{data_sram_wen[0]}}};
  assign w_wr     = data_sram_en && w_mmio && |data_sram_wen;
  assign w_led_we = w_wr && w_off == 14'h0;
  assign w_tmr_we = w_wr && w_off == 14'h2;
  assign w_cmp_we = w_wr && w_off == 14'h3;
  assign w_st_clr = w_wr && w_off == 14'h4 && data_sram_wen[0] && data_sram_wdata[0];
  assign w_mmio_rd = w_off == 14'h0 ? {16'h0, r_led} :
                     w_off == 14'h1 ? {24'h0, r_sw_sync} :
                     w_off == 14'h2 ? r_timer :
                     w_off == 14'h3 ? r_compare :
                     w_off == 14'h4 ? {31'h0, r_status} : 32'h0;
  // RAM has no reset so its contents survive resetn
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (data_sram_en && !w_mmio && data_sram_wen[i]) r_ram[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata   <= '0;
      r_led     <= '0;
      r_timer   <= '0;
      r_compare <= '1;
      r_status  <= 1'b0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      if (data_sram_en) r_rdata <= w_mmio ? w_mmio_rd : r_ram[w_idx];
      if (w_led_we) r_led <= (data_sram_wdata[15:0] & w_mask[15:0]) | (r_led & ~w_mask[15:0]);
      r_timer   <= w_tmr_we ? (data_sram_wdata & w_mask) | (r_timer & ~w_mask) : r_timer + 32'd1;
      if (w_cmp_we) r_compare <= (data_sram_wdata & w_mask) | (r_compare & ~w_mask);
      // a match in the same cycle as a clear wins
      r_status  <= (r_timer == r_compare) || (r_status && !w_st_clr);
      r_sw_meta <= switch;
      r_sw_sync <= r_sw_meta;
    end
  end
  assign data_sram_rdata = r_rdata;
  assign led             = r_led;
  assign timer_irq       = r_status;
endmodule
